// File: rtl/div_result_fifo.sv
// div_result_fifo: result FIFO behind the pipelined fixed-point divider.
// Each divider result (quotient plus div-by-zero flag) is captured into a
// small FIFO and offered on a valid/ready port. The divider cannot be
// stalled, so operations in flight are tracked and a credit (can_issue)
// tells the issuing logic when one more start is safe.
// Optional build macro DIV_RESULT_SAT_EN: when defined, a div-by-zero result
// is stored as the maximum positive quotient instead of the raw value.
module div_result_fifo #(
  parameter  int BITS  = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  output logic             can_issue,
  input  logic             data_valid,
  input  logic             div_by_zero,
  input  logic [BITS-1:0]  quotient,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_data,
  output logic             out_dbz,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             protocol_err
);

  typedef logic [BITS:0] entry_t;

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   inflight;
  logic [PTR_W+1:0] committed;
  logic [BITS-1:0]  quotient_mapped;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  // Handshake decode; a pop frees a slot in the same cycle, so a push at full
  // is accepted when the head leaves at the same edge.
  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = data_valid && (!full || pop);
  assign drop      = data_valid && full && !pop;

  // Credit counts both stored results and results still inside the divider;
  // it deliberately ignores a pop happening in the same cycle.
  assign committed = {1'b0, count} + {1'b0, inflight};
  assign can_issue = (committed < DEPTH_W);

  assign out_data = mem[rd_ptr][BITS-1:0];
  assign out_dbz  = mem[rd_ptr][BITS];

  // Map the incoming quotient to the value actually stored.
  always_comb begin
    // NOTE: assign a default first so every path writes the signal and no latch is inferred.
    quotient_mapped = quotient;
`ifdef DIV_RESULT_SAT_EN
    if (div_by_zero) quotient_mapped = {1'b0, {(BITS-1){1'b1}}};
`endif
  end

  // Result storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset because out_data/out_dbz must read zero after reset; storage that needs no defined reset value should be left unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
      mem[wr_ptr] <= {div_by_zero, quotient_mapped};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // In-flight tracking (saturating, never wrapping) and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= '0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (start_in && !data_valid) begin
        if (inflight != DEPTH_C) inflight <= inflight + CNT_ONE;
      end else if (data_valid && !start_in) begin
        if (inflight != '0) inflight <= inflight - CNT_ONE;
      end
      if (data_valid && (inflight == '0)) protocol_err <= 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_result_fifo.sv
// Testbench for div_result_fifo (BITS=8, DEPTH=4). A queue-based model of
// the FIFO, in-flight count and sticky flags predicts every output after
// each clock edge; directed scenarios are followed by randomized traffic.
module tb_div_result_fifo;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk;
  logic             rst;
  logic             start_in;
  logic             can_issue;
  logic             data_valid;
  logic             div_by_zero;
  logic [BITS-1:0]  quotient;
  logic             out_valid;
  logic             out_ready;
  logic [BITS-1:0]  out_data;
  logic             out_dbz;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             protocol_err;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [BITS:0] mq[$];
  int            m_inflight;
  bit            m_ovf;
  bit            m_perr;

  div_result_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .can_issue    (can_issue),
    .data_valid   (data_valid),
    .div_by_zero  (div_by_zero),
    .quotient     (quotient),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dbz      (out_dbz),
    .count        (count),
    .overflow     (overflow),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] map_q(input logic dbz, input logic [BITS-1:0] q);
`ifdef DIV_RESULT_SAT_EN
    return dbz ? 8'h7F : q;
`else
    return q;
`endif
  endfunction

  function automatic bit model_can_issue();
    return (mq.size() + m_inflight) < DEPTH;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs present at the coming edge, then clock.
  task automatic tick();
    bit full;
    bit pop;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && out_ready;
    if (rst) begin
      mq.delete();
      m_inflight = 0;
      m_ovf      = 0;
      m_perr     = 0;
    end else begin
      if (data_valid && m_inflight == 0) m_perr = 1;
      if (pop) void'(mq.pop_front());
      if (data_valid) begin
        if (!full || pop) mq.push_back({div_by_zero, map_q(div_by_zero, quotient)});
        else              m_ovf = 1;
      end
      if (start_in && !data_valid && m_inflight < DEPTH) m_inflight++;
      else if (data_valid && !start_in && m_inflight > 0) m_inflight--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    check("out_valid", out_valid, mq.size() != 0);
    check("count", count, mq.size());
    check("can_issue", can_issue, model_can_issue());
    check("overflow", overflow, m_ovf);
    check("protocol_err", protocol_err, m_perr);
    if (mq.size() != 0) begin
      check("out_data", out_data, mq[0][BITS-1:0]);
      check("out_dbz", out_dbz, mq[0][BITS]);
    end
  endtask

  task automatic drive(input logic s, input logic dv, input logic dbz,
                       input logic [BITS-1:0] q, input logic r);
    start_in    = s;
    data_valid  = dv;
    div_by_zero = dbz;
    quotient    = q;
    out_ready   = r;
    tick();
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_in = 0; data_valid = 0; div_by_zero = 0; quotient = '0; out_ready = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_state();
    check("rst_out_valid", out_valid, 0);
    check("rst_can_issue", can_issue, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_dbz", out_dbz, 0);

    // Single operation: visible one cycle after the strobe, popped next cycle
    drive(1, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 1);
    drive(0, 1, 0, 8'h20, 1);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 8'h20);
    drive(0, 0, 0, 8'h00, 1);
    check("single_drained", count, 0);

    // Credit exhaustion and ordering
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 8'h00, 0);
    check("credit_exhausted", can_issue, 0);
    for (int i = 1; i <= DEPTH; i++) drive(0, 1, 0, BITS'(i), 0);
    check("full_count", count, DEPTH);
    check("full_no_credit", can_issue, 0);
    check("head_first", out_data, 8'h01);
    drive(0, 0, 0, 8'h00, 1);
    check("credit_back", can_issue, 1);
    check("head_second", out_data, 8'h02);

    // Refill, then drop at full with no pop
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 1, 0, 8'h05, 0);
    drive(1, 0, 0, 8'h00, 0);           // issued without credit
    drive(0, 1, 0, 8'h06, 0);
    check("drop_overflow", overflow, 1);
    check("drop_count", count, DEPTH);
    check("drop_head", out_data, 8'h02);

    // Push and pop at full: count holds, new entry goes to the tail
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 1, 0, 8'h07, 1);
    check("pushpop_full_count", count, DEPTH);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 8'h00, 1);
    check("drained", count, 0);

    // Div-by-zero entry
    do_reset();
    check_state();
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 1, 1, 8'hA5, 0);
    check("dbz_flag", out_dbz, 1);
`ifdef DIV_RESULT_SAT_EN
    check("dbz_data", out_data, 8'h7F);
`else
    check("dbz_data", out_data, 8'hA5);
`endif

    // Result with nothing in flight
    do_reset();
    drive(0, 1, 0, 8'h33, 0);
    check("perr_set", protocol_err, 1);
    check("perr_stored", count, 1);
    drive(1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    check("perr_inflight_zero", can_issue, 1);
    drive(1, 0, 0, 8'h00, 0);
    check("perr_credit_limit", can_issue, 0);

    // Randomized traffic, mostly well-behaved with occasional protocol abuse
    do_reset();
    check_state();
    for (int n = 0; n < 600; n++) begin
      logic s, dv, dbz, r;
      logic [BITS-1:0] q;
      s   = (model_can_issue() && $urandom_range(0, 99) < 60) || ($urandom_range(0, 99) < 3);
      dv  = (m_inflight > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 99) < 2);
      dbz = ($urandom_range(0, 7) == 0);
      q   = BITS'($urandom);
      r   = ($urandom_range(0, 99) < 50);
      drive(s, dv, dbz, q, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
